ofdm_bit_encoder: RTL and testbench

Transmit-side bit pipeline for legacy 802.11a/g OFDM. It takes a PSDU byte stream and inserts 16 SERVICE bits, then scrambles the data. It appends 6 tail bits and pads to a whole number of OFDM symbols. It then convolutionally encodes (K=7, g0=133o, g1=171o) and punctures to the frame rate. Output is a serial coded-bit stream with valid/ready, feeding the TX interleaver/mapper; it mirrors the RX descramble/Viterbi/bits-to-bytes path.

---
 rtl/ofdm_bit_encoder_if.sv | 17 +
 rtl/ofdm_bit_encoder.sv | 117 +++++++++++
 tb/tb_ofdm_bit_encoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ofdm_bit_encoder_if.sv
// ofdm_bit_encoder_if: frame control, byte input and coded-bit output bundle
interface ofdm_bit_encoder_if;
  logic enable, start, do_scramble, byte_in_strobe, byte_in_ready;
  logic coded_bit, coded_valid, coded_ready, busy, done;
  logic [3:0] rate;
  logic [6:0] scram_seed;
  logic [11:0] num_bytes;
  logic [7:0] byte_in;
  modport master(
    output enable, start, rate, do_scramble, scram_seed, num_bytes, byte_in, byte_in_strobe, coded_ready,
    input byte_in_ready, coded_bit, coded_valid, busy, done
  );
  modport slave(
    input enable, start, rate, do_scramble, scram_seed, num_bytes, byte_in, byte_in_strobe, coded_ready,
    output byte_in_ready, coded_bit, coded_valid, busy, done
  );
endinterface

// File: rtl/ofdm_bit_encoder.sv
// ofdm_bit_encoder: 802.11a/g service/scramble/tail/pad, K=7 encoder, puncturing when OFDM_ENC_PUNCTURE_EN
module ofdm_bit_encoder (
  input logic clock,
  input logic reset,
  ofdm_bit_encoder_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SERVICE = 3'd1, DATA = 3'd2, TAIL = 3'd3, PAD = 3'd4, DRAIN = 3'd5;
  logic [2:0] state;
  logic raw, ph, fb, d, a, b, ka, kb, have, free, last, step, sym_wrap;
  logic [3:0] rate_q, cnt, sh_n;
  logic [6:0] scr;
  logic [5:0] hist;
  logic [7:0] sym, sh, ndbps;
  logic [11:0] left;
`ifdef OFDM_ENC_PUNCTURE_EN
  logic [1:0] pc;
  logic p23, p34;
`endif
  assign bus.byte_in_ready = state == DATA && sh_n == 4'd0 && left != 12'd0;
  always_comb begin
    ndbps = rate_q == 4'b1011 ? 8'd24 : rate_q == 4'b1111 ? 8'd36 : rate_q == 4'b1010 ? 8'd48 :
            rate_q == 4'b1110 ? 8'd72 : rate_q == 4'b1001 ? 8'd96 : rate_q == 4'b1101 ? 8'd144 :
            rate_q == 4'b1000 ? 8'd192 : 8'd216;
    fb = scr[6] ^ scr[3];
    d = state == TAIL ? 1'b0 : ((state == DATA) & sh[0]) ^ (fb & ~raw);
    a = d ^ hist[1] ^ hist[2] ^ hist[4] ^ hist[5];
    b = d ^ hist[0] ^ hist[1] ^ hist[2] ^ hist[5];
    have = state == SERVICE || state == TAIL || state == PAD || (state == DATA && sh_n != 4'd0);
    free = ~bus.coded_valid | bus.coded_ready;
    sym_wrap = sym == ndbps - 8'd1;
`ifdef OFDM_ENC_PUNCTURE_EN
    p23 = rate_q == 4'b1000;
    p34 = rate_q[3:2] == 2'b11;
    ka = ~(p34 && pc == 2'd2);
    kb = pc == 2'd0 || (p34 && pc == 2'd2);
`else
    ka = 1'b1;
    kb = 1'b1;
`endif
    last = ph | ~ka | ~kb;
    step = bus.enable & have & free & last;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      raw <= 1'b0;
      rate_q <= 4'd0;
      cnt <= 4'd0;
      sh_n <= 4'd0;
      scr <= 7'd0;
      hist <= 6'd0;
      sym <= 8'd0;
      sh <= 8'd0;
      left <= 12'd0;
      ph <= 1'b0;
      bus.coded_bit <= 1'b0;
      bus.coded_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
`ifdef OFDM_ENC_PUNCTURE_EN
      pc <= 2'd0;
`endif
    end else if (bus.enable) begin
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        rate_q <= bus.rate;
        raw <= ~bus.do_scramble;
        scr <= bus.scram_seed == 7'd0 ? 7'h7f : bus.scram_seed;
        hist <= 6'd0;
        sym <= 8'd0;
        cnt <= 4'd0;
        sh_n <= 4'd0;
        ph <= 1'b0;
        left <= bus.num_bytes;
`ifdef OFDM_ENC_PUNCTURE_EN
        pc <= 2'd0;
`endif
        bus.done <= bus.num_bytes == 12'd0;
        bus.busy <= bus.num_bytes != 12'd0;
        state <= bus.num_bytes == 12'd0 ? IDLE : bus.do_scramble ? SERVICE : DATA;
      end
      if (bus.byte_in_ready && bus.byte_in_strobe) begin
        sh <= bus.byte_in;
        sh_n <= 4'd8;
        left <= left - 12'd1;
      end
      if (free) bus.coded_valid <= have;
      if (free && have) begin
        bus.coded_bit <= (ph | ~ka) ? b : a;
        ph <= ~last;
      end
      // scrambler, encoder history and counters move only once the bit's last kept output is issued
      if (step) begin
        hist <= {hist[4:0], d};
        scr <= {scr[5:0], fb};
        sym <= sym_wrap ? 8'd0 : sym + 8'd1;
        cnt <= state == DATA ? 4'd0 : cnt + 4'd1;
`ifdef OFDM_ENC_PUNCTURE_EN
        pc <= (p23 && pc == 2'd1) || (p34 && pc == 2'd2) || !(p23 || p34) ? 2'd0 : pc + 2'd1;
`endif
        if (state == SERVICE && cnt == 4'd15) state <= DATA;
        if (state == DATA) begin
          sh <= sh >> 1;
          sh_n <= sh_n - 4'd1;
          if (sh_n == 4'd1 && left == 12'd0) state <= raw ? DRAIN : TAIL;
        end
        if (state == TAIL && cnt == 4'd5) state <= sym_wrap ? DRAIN : PAD;
        if (state == PAD && sym_wrap) state <= DRAIN;
      end
      if (state == DRAIN && free) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ofdm_bit_encoder.sv
// tb_ofdm_bit_encoder: randomized frames checked against a bit-level 802.11a reference model
module tb_ofdm_bit_encoder;
  logic clock = 1'b0, reset = 1'b1;
  int tests = 0, fails = 0;
  logic [7:0] bytes_q[$];
  bit bits_q[$], exp_q[$], got_q[$];
  logic [3:0] rates [8] = '{4'b1011, 4'b1111, 4'b1010, 4'b1110, 4'b1001, 4'b1101, 4'b1000, 4'b1100};
  ofdm_bit_encoder_if bus();
  ofdm_bit_encoder dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_in_ready), 0);
    check({tag, "_bit"}, 32'(bus.coded_bit), 0);
    check({tag, "_valid"}, 32'(bus.coded_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask

  function automatic int ndbps(input logic [3:0] r);
    case (r)
      4'b1011: return 24;
      4'b1111: return 36;
      4'b1010: return 48;
      4'b1110: return 72;
      4'b1001: return 96;
      4'b1101: return 144;
      4'b1000: return 192;
      default: return 216;
    endcase
  endfunction

  function automatic bit tap(input int i);
    return i < 0 ? 1'b0 : bits_q[i];
  endfunction

  task automatic model(input logic [3:0] r, input bit scr, input logic [6:0] seed);
    int nb, per, k;
    logic [6:0] s;
    bit fbk, a, b;
    nb = bytes_q.size();
    per = 1;
`ifdef OFDM_ENC_PUNCTURE_EN
    per = r == 4'b1000 ? 2 : (r == 4'b1111 || r == 4'b1110 || r == 4'b1101 || r == 4'b1100) ? 3 : 1;
`endif
    bits_q = {};
    exp_q = {};
    if (nb == 0) return;
    if (scr) repeat (16) bits_q.push_back(1'b0);
    foreach (bytes_q[i]) for (int j = 0; j < 8; j++) bits_q.push_back(bytes_q[i][j]);
    if (scr) begin
      repeat (6) bits_q.push_back(1'b0);
      while (bits_q.size() % ndbps(r) != 0) bits_q.push_back(1'b0);
      s = seed == 7'd0 ? 7'h7f : seed;
      foreach (bits_q[i]) begin
        fbk = s[6] ^ s[3];
        bits_q[i] = bits_q[i] ^ fbk;
        s = {s[5:0], fbk};
      end
      for (int i = 0; i < 6; i++) bits_q[16 + 8 * nb + i] = 1'b0;
    end
    foreach (bits_q[i]) begin
      a = tap(i) ^ tap(i - 2) ^ tap(i - 3) ^ tap(i - 5) ^ tap(i - 6);
      b = tap(i) ^ tap(i - 1) ^ tap(i - 2) ^ tap(i - 3) ^ tap(i - 6);
      k = i % per;
      if (!(per == 3 && k == 2)) exp_q.push_back(a);
      if (k == 0 || (per == 3 && k == 2)) exp_q.push_back(b);
    end
  endtask

  task automatic run(input logic [3:0] r, input bit scr, input logic [6:0] seed, input bit rnd,
                     input int abort_at, output int busy_cyc, output int first_v);
    int cyc, bi, nerr;
    bit fin, stalled, held;
    cyc = 0; bi = 0; nerr = 0; fin = 0; stalled = 0; held = 0;
    busy_cyc = 0; first_v = -1; got_q = {};
    model(r, scr, seed);
    @(negedge clock);
    bus.rate = r; bus.do_scramble = scr; bus.scram_seed = seed;
    bus.num_bytes = 12'(bytes_q.size()); bus.start = 1'b1; bus.enable = 1'b1;
    while (!fin && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      bus.start = 1'b0;
      if (cyc == abort_at) begin
        reset = 1'b1;
        bus.byte_in_strobe = 1'b0; bus.enable = 1'b1; bus.coded_ready = 1'b1;
        @(negedge clock);
        check_idle("abort");
        reset = 1'b0;
        return;
      end
      if (bus.busy) busy_cyc++;
      if (bus.coded_valid && first_v < 0) first_v = cyc;
      if (stalled) begin
        check("hold_valid", 32'(bus.coded_valid), 1);
        check("hold_bit", 32'(bus.coded_bit), 32'(held));
      end
      if (bus.done) begin
        fin = 1;
        check("busy_at_done", 32'(bus.busy), 0);
      end else begin
        bus.enable = rnd ? ($urandom_range(3) != 0) : 1'b1;
        bus.coded_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        bus.byte_in_strobe = bi < bytes_q.size() && (!rnd || $urandom_range(1) == 1);
        bus.byte_in = bi < bytes_q.size() ? bytes_q[bi] : 8'h00;
        if (bus.enable && bus.byte_in_strobe && bus.byte_in_ready) bi++;
        if (bus.enable && bus.coded_valid && bus.coded_ready) got_q.push_back(bus.coded_bit);
        stalled = bus.coded_valid && !(bus.enable && bus.coded_ready);
        held = bus.coded_bit;
      end
    end
    bus.byte_in_strobe = 1'b0; bus.enable = 1'b1; bus.coded_ready = 1'b1;
    check("done_seen", 32'(fin), 1);
    check("len", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] != exp_q[i]) nerr++;
    check("bits", nerr, 0);
  endtask

  initial begin
    int bc, fv;
    logic [15:0] pk;
    logic [3:0] r;
    bus.enable = 1'b1; bus.start = 1'b0; bus.rate = 4'd0; bus.do_scramble = 1'b0;
    bus.scram_seed = 7'd0; bus.num_bytes = 12'd0; bus.byte_in = 8'd0;
    bus.byte_in_strobe = 1'b0; bus.coded_ready = 1'b1;
    repeat (3) @(negedge clock);
    check_idle("rst");
    reset = 1'b0;
    bytes_q = {8'h01};
    run(4'b1011, 1'b0, 7'd0, 1'b0, 0, bc, fv);
    pk = 16'd0;
    for (int i = 0; i < 16 && i < got_q.size(); i++) pk = {pk[14:0], got_q[i]};
    check("raw6_pairs", 32'(pk), 32'h0000DF2C);
    check("raw6_busy", bc, 18);
    check("raw6_first", fv, 3);
    bytes_q = {};
    run(4'b1011, 1'b1, 7'h7f, 1'b0, 0, bc, fv);
    check("empty_busy", bc, 0);
    check("empty_valid", fv, -1);
    bytes_q = {8'h00};
    run(4'b1011, 1'b1, 7'h7f, 1'b0, 0, bc, fv);
    pk = 16'd0;
    for (int i = 0; i < 10 && i < got_q.size(); i++) pk = {pk[14:0], got_q[i]};
    check("svc_head", 32'(pk), 3);
    check("svc_len", got_q.size(), 96);
    check("svc_first", fv, 2);
    bytes_q = {};
    repeat (25) bytes_q.push_back(8'($urandom));
    run(4'b1100, 1'b1, 7'($urandom), 1'b0, 0, bc, fv);
`ifdef OFDM_ENC_PUNCTURE_EN
    check("r54_len", got_q.size(), 576);
`else
    check("r54_len", got_q.size(), 864);
`endif
    bytes_q = {8'h01};
    run(4'b1000, 1'b0, 7'd0, 1'b0, 0, bc, fv);
`ifdef OFDM_ENC_PUNCTURE_EN
    check("r48_len", got_q.size(), 12);
`else
    check("r48_len", got_q.size(), 16);
`endif
    for (int t = 0; t < 10; t++) begin
      r = rates[$urandom_range(7)];
      bytes_q = {};
      repeat ($urandom_range(30, 1)) bytes_q.push_back(8'($urandom));
      run(r, 1'($urandom_range(1)), 7'($urandom), 1'b1, 0, bc, fv);
    end
    bytes_q = {};
    repeat (10) bytes_q.push_back(8'($urandom));
    run(4'b1010, 1'b1, 7'h25, 1'b0, 45, bc, fv);
    run(4'b1010, 1'b1, 7'h25, 1'b0, 0, bc, fv);
    check("after_abort_first", fv, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
